// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_types_pkg
//  Description : Shared word type and the dump-engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package common_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD_ACC = 3'd1,
    ST_LD_WR  = 3'd2,
    ST_DP_RD  = 3'd3,
    ST_DP_OUT = 3'd4,
    ST_DONE   = 3'd5
  } dump_state_t;

endpackage : common_types_pkg
`default_nettype wire

// File: rtl/ram_dump_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dump_engine
//  Description : Debug-port initiator that loads a program image into RAM
//                while holding the CPU, then dumps RAM once the CPU halts.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_dump_engine
  import common_types_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        halt,
  input  logic        load_start,
  input  word_t       load_data,
  input  logic        load_last,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        override_ctrl,
  output logic        iren,
  output logic        dren,
  output logic        dwen,
  output word_t       iaddr,
  output word_t       daddr,
  output word_t       dstore,
  input  logic        dwait,
  input  word_t       dload,
  output word_t       dump_addr,
  output word_t       dump_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic        dump_done,
  output logic        load_ovf
);

  localparam int               CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  dump_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  word_t            daddr_q, daddr_d;
  word_t            dstore_q, dstore_d;
  word_t            dump_data_q, dump_data_d;
  word_t            dump_addr_q, dump_addr_d;

  function automatic word_t addr_of(input logic [CNT_W-1:0] idx);
    return BASE_ADDR + (word_t'(idx) << 2);
  endfunction

  // The address is latched on entry to a request state so it is already
  // stable in the first request cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_nx      = cnt_q + 1'b1;
    last_d      = last_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    daddr_d     = daddr_q;
    dstore_d    = dstore_q;
    dump_data_d = dump_data_q;
    dump_addr_d = dump_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LD_ACC;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          done_d  = 1'b0;
        end else if (halt && !done_q) begin
          state_d = ST_DP_RD;
          cnt_d   = '0;
          daddr_d = addr_of('0);
        end
      end
      ST_LD_ACC: begin
        if (load_valid) begin
          dstore_d = load_data;
          last_d   = load_last;
          daddr_d  = addr_of(cnt_q);
          state_d  = ST_LD_WR;
        end
      end
      ST_LD_WR: begin
        if (!dwait) begin
          cnt_d = cnt_nx;
          if (last_q) begin
            state_d = ST_IDLE;
          end else if (cnt_nx == CNT_FULL) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b1;
          end else begin
            state_d = ST_LD_ACC;
          end
        end
      end
      ST_DP_RD: begin
        if (!dwait) begin
          dump_data_d = dload;
          dump_addr_d = daddr_q;
          state_d     = ST_DP_OUT;
        end
      end
      ST_DP_OUT: begin
        if (dump_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_nx;
            daddr_d = addr_of(cnt_nx);
            state_d = ST_DP_RD;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      daddr_q     <= '0;
      dstore_q    <= '0;
      dump_data_q <= '0;
      dump_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      daddr_q     <= daddr_d;
      dstore_q    <= dstore_d;
      dump_data_q <= dump_data_d;
      dump_addr_q <= dump_addr_d;
    end
  end

  assign load_ready    = (state_q == ST_LD_ACC);
  assign dwen          = (state_q == ST_LD_WR);
  assign dren          = (state_q == ST_DP_RD);
  assign dump_valid    = (state_q == ST_DP_OUT);
  assign cpu_hold      = (state_q == ST_LD_ACC) || (state_q == ST_LD_WR);
  assign override_ctrl = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign iren          = 1'b0;
  assign iaddr         = '0;
  assign daddr         = daddr_q;
  assign dstore        = dstore_q;
  assign dump_data     = dump_data_q;
  assign dump_addr     = dump_addr_q;
  assign dump_done     = done_q;
  assign load_ovf      = ovf_q;

endmodule : ram_dump_engine
`default_nettype wire

// File: tb/tb_ram_dump_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_dump_engine
//  Description : Directed vector table plus multi-cycle sequences for the
//                RAM load/dump engine (BASE_ADDR=0, NUM_WORDS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dump_engine;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        halt = 1'b0, load_start = 1'b0, load_last = 1'b0, load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        dump_ready = 1'b0;
  logic        load_ready, cpu_hold, override_ctrl, iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore, dump_addr, dump_data;
  logic        dump_valid, dump_done, load_ovf;
  logic        dwait;
  logic [31:0] dload;

  logic        mem_en = 1'b0, mem_clr = 1'b0;
  logic        v_dwait = 1'b0;
  logic [31:0] v_dload = '0;
  logic        m_dwait;
  logic [31:0] mem [16];
  logic [31:0] wr_log [8];
  int          wcnt, wait_n, wr_n, rd_n;
  int          n_chk = 0, n_fail = 0;

  ram_dump_engine #(.BASE_ADDR(32'h0), .NUM_WORDS(4)) dut (
    .clk(clk), .nrst(nrst), .halt(halt), .load_start(load_start),
    .load_data(load_data), .load_last(load_last), .load_valid(load_valid),
    .load_ready(load_ready), .cpu_hold(cpu_hold), .override_ctrl(override_ctrl),
    .iren(iren), .dren(dren), .dwen(dwen), .iaddr(iaddr), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_done(dump_done), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  // RAM model: each request waits wait_n cycles before completing.
  assign m_dwait = (dwen || dren) && (wcnt < wait_n);
  assign dwait   = mem_en ? m_dwait : v_dwait;
  assign dload   = mem_en ? mem[daddr[5:2]] : v_dload;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i < 4) ? 32'(i + 1) : 32'd0;
      wr_n <= 0; rd_n <= 0; wcnt <= 0;
    end else if (mem_en && (dwen || dren)) begin
      if (!m_dwait) begin
        wcnt <= 0;
        if (dwen) begin
          mem[daddr[5:2]]   <= dstore;
          wr_log[wr_n[2:0]] <= daddr;
          wr_n              <= wr_n + 1;
        end else begin
          rd_n <= rd_n + 1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  typedef struct {
    logic [5:0]  in6;   // {load_start, load_valid, load_last, halt, dump_ready, dwait}
    logic [31:0] ld, dl;
    logic [7:0]  ex;    // {rdy, hold, ovr, dwen, dren, dvalid, done, ovf}
    logic [31:0] ea, es, edd, eda;
  } vec_t;

  function automatic vec_t mkv(input logic [5:0] in6, input logic [31:0] ld, dl,
                               input logic [7:0] ex, input logic [31:0] ea, es, edd, eda);
    vec_t v;
    v.in6 = in6; v.ld = ld; v.dl = dl; v.ex = ex;
    v.ea = ea; v.es = es; v.edd = edd; v.eda = eda;
    return v;
  endfunction

  function automatic logic [7:0] ctl();
    return {load_ready, cpu_hold, override_ctrl, dwen, dren, dump_valid, dump_done, load_ovf};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic feed(input logic [31:0] d, input logic l, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (load_ready) begin
        load_valid = 1'b1; load_data = d; load_last = l;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  vec_t        vecs [21];
  logic [31:0] exp_d [4];

  initial begin
    bit ok;
    int acc, t;

    vecs[0]  = mkv(6'b000000, 0, 0, 8'b00000000, 0, 0, 0, 0);
    vecs[1]  = mkv(6'b100000, 0, 0, 8'b11100000, 0, 0, 0, 0);
    vecs[2]  = mkv(6'b010000, 32'hDEADBEEF, 0, 8'b01110000, 32'h0, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mkv(6'b000001, 0, 0, 8'b01110000, 32'h0, 32'hDEADBEEF, 0, 0);
    vecs[4]  = mkv(6'b000001, 0, 0, 8'b01110000, 32'h0, 32'hDEADBEEF, 0, 0);
    vecs[5]  = mkv(6'b000000, 0, 0, 8'b11100000, 0, 0, 0, 0);
    vecs[6]  = mkv(6'b011000, 32'h13, 0, 8'b01110000, 32'h4, 32'h13, 0, 0);
    vecs[7]  = mkv(6'b000000, 0, 0, 8'b00000000, 0, 0, 0, 0);
    vecs[8]  = mkv(6'b000100, 0, 0, 8'b00101000, 32'h0, 0, 0, 0);
    vecs[9]  = mkv(6'b000100, 0, 32'h1111, 8'b00100100, 0, 0, 32'h1111, 32'h0);
    vecs[10] = mkv(6'b000000, 0, 0, 8'b00100100, 0, 0, 32'h1111, 32'h0);
    vecs[11] = mkv(6'b000010, 0, 0, 8'b00101000, 32'h4, 0, 0, 0);
    vecs[12] = mkv(6'b000001, 0, 0, 8'b00101000, 32'h4, 0, 0, 0);
    vecs[13] = mkv(6'b000000, 0, 32'h2222, 8'b00100100, 0, 0, 32'h2222, 32'h4);
    vecs[14] = mkv(6'b000010, 0, 0, 8'b00101000, 32'h8, 0, 0, 0);
    vecs[15] = mkv(6'b000000, 0, 32'h3333, 8'b00100100, 0, 0, 32'h3333, 32'h8);
    vecs[16] = mkv(6'b000010, 0, 0, 8'b00101000, 32'hC, 0, 0, 0);
    vecs[17] = mkv(6'b000000, 0, 32'h4444, 8'b00100100, 0, 0, 32'h4444, 32'hC);
    vecs[18] = mkv(6'b000010, 0, 0, 8'b00000000, 0, 0, 0, 0);
    vecs[19] = mkv(6'b000100, 0, 0, 8'b00000010, 0, 0, 0, 0);
    vecs[20] = mkv(6'b000100, 0, 0, 8'b00000010, 0, 0, 0, 0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset ctl", 32'(ctl()), 32'h0);
    chk("reset iren", {31'd0, iren}, 32'h0);
    chk("reset iaddr", iaddr, 32'h0);
    chk("reset daddr", daddr, 32'h0);
    chk("reset dstore", dstore, 32'h0);
    chk("reset dump_data", dump_data, 32'h0);
    chk("reset dump_addr", dump_addr, 32'h0);
    nrst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      {load_start, load_valid, load_last, halt, dump_ready, v_dwait} = vecs[i].in6;
      load_data = vecs[i].ld;
      v_dload   = vecs[i].dl;
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i), 32'(ctl()), 32'(vecs[i].ex));
      if (vecs[i].ex[4] || vecs[i].ex[3]) chk($sformatf("vec%0d daddr", i), daddr, vecs[i].ea);
      if (vecs[i].ex[4]) chk($sformatf("vec%0d dstore", i), dstore, vecs[i].es);
      if (vecs[i].ex[2]) begin
        chk($sformatf("vec%0d dump_data", i), dump_data, vecs[i].edd);
        chk($sformatf("vec%0d dump_addr", i), dump_addr, vecs[i].eda);
      end
    end
    {load_start, load_valid, load_last, halt, dump_ready, v_dwait} = 6'b0;

    // Asynchronous reset in the middle of a stalled write
    mem_en = 1'b1; mem_clr = 1'b1; wait_n = 10;
    @(negedge clk);
    mem_clr = 1'b0;
    pulse_start();
    feed(32'hCAFE0001, 1'b0, ok);
    chk("rst seq accept", {31'd0, ok}, 32'd1);
    chk("rst seq dwen", {31'd0, dwen}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("mid-write reset ctl", 32'(ctl()), 32'h0);
    chk("mid-write reset no write", 32'(wr_n), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Load and halt in the same cycle: load wins, dump follows
    wait_n = 2;
    halt = 1'b1;
    pulse_start();
    chk("simul ld_acc ready", {31'd0, load_ready}, 32'd1);
    chk("simul no dren", {31'd0, dren}, 32'd0);
    feed(32'hA0A0A0A0, 1'b0, ok);
    feed(32'hA1A1A1A1, 1'b1, ok);
    for (t = 0; t < 20 && cpu_hold; t++) @(negedge clk);
    chk("load end hold", {31'd0, cpu_hold}, 32'd0);
    chk("load writes", 32'(wr_n), 32'd2);
    chk("load no reads", 32'(rd_n), 32'd0);
    chk("ram word0", mem[0], 32'hA0A0A0A0);
    chk("ram word1", mem[1], 32'hA1A1A1A1);
    chk("load ovf clear", {31'd0, load_ovf}, 32'd0);

    exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hA1A1A1A1; exp_d[2] = 32'd3; exp_d[3] = 32'd4;
    for (int k = 0; k < 4; k++) begin
      for (t = 0; t < 20 && !dump_valid; t++) @(negedge clk);
      chk($sformatf("dump%0d valid", k), {31'd0, dump_valid}, 32'd1);
      chk($sformatf("dump%0d addr", k), dump_addr, 32'(k * 4));
      chk($sformatf("dump%0d data", k), dump_data, exp_d[k]);
      if (k % 2 == 0) begin
        dump_ready = 1'b0;
        if (k == 0) load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk($sformatf("dump%0d stall data", k), dump_data, exp_d[k]);
        chk($sformatf("dump%0d stall ctl", k), 32'(ctl()), 32'h24);
      end
      dump_ready = 1'b1;
      @(negedge clk);
      dump_ready = 1'b0;
    end
    for (t = 0; t < 10 && !dump_done; t++) @(negedge clk);
    chk("dump done", {31'd0, dump_done}, 32'd1);
    repeat (5) @(negedge clk);
    chk("no second dump", 32'(rd_n), 32'd4);

    halt = 1'b0;
    pulse_start();
    chk("rearm done clear", {31'd0, dump_done}, 32'd0);
    chk("rearm ld_acc", {31'd0, load_ready}, 32'd1);

    // Overflow: five words without load_last into a four-word window
    mem_clr = 1'b1; wait_n = 0;
    @(negedge clk);
    mem_clr = 1'b0;
    acc = 0;
    for (int w = 0; w < 5; w++) begin
      feed(32'h5000_0000 + 32'(w), 1'b0, ok);
      if (ok) acc++;
    end
    chk("ovf accepted", 32'(acc), 32'd4);
    chk("ovf writes", 32'(wr_n), 32'd4);
    for (int w = 0; w < 4; w++) chk($sformatf("ovf addr%0d", w), wr_log[w], 32'(w * 4));
    chk("ovf flag", {31'd0, load_ovf}, 32'd1);
    chk("ovf ready low", {31'd0, load_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected below");
    $fatal(1);
  end

endmodule : tb_ram_dump_engine
`default_nettype wire

// File: doc/ram_dump_engine.md
# ram_dump_engine

Hardware initiator for the system debug RAM port, taking the testbench's role on the override path. On request it takes memory-controller ownership, writes a program image from an input word stream into the shared RAM while holding the CPU, and releases control. After the CPU raises `halt`, it reads the RAM back word by word and streams the contents out. It sits beside `cpu` in the system top, and its debug-port outputs feed the override muxes ahead of `memory_control`.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word loaded or dumped; must be word-aligned.
- `NUM_WORDS`, default 1024: number of 32-bit words in the load/dump window.
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous active-low reset.
- `halt`  in  1  CPU halt flag.
- `load_start`  in  1  single-cycle pulse that begins a load.
- `load_data`  in  32  next image word.
- `load_last`  in  1  marks the final image word; qualified by `load_valid`.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  engine accepts a load word this cycle.
- `cpu_hold`  out  1  keeps the CPU in reset during a load; the system top ANDs its inverse into CPU `nrst`.
- `override_ctrl`  out  1  selects engine control of the memory controller.
- `iren`, `dren`, `dwen`  out  1 each  memory requests; `iren` is always 0.
- `iaddr`, `daddr`  out  32  addresses; `iaddr` is always 0.
- `dstore`  out  32  write data.
- `dwait`  in  1  memory busy; an access completes in a cycle where the request is high and `dwait` is low.
- `dload`  in  32  read data, valid in the completing cycle.
- `dump_addr`  out  32  byte address of `dump_data`.
- `dump_data`  out  32  word read from RAM.
- `dump_valid`  out  1  dump word is available.
- `dump_ready`  in  1  sink accepts the dump word.
- `dump_done`  out  1  sticky; the dump has completed.
- `load_ovf`  out  1  sticky; a load hit `NUM_WORDS` without seeing `load_last`.

## Operation
- The state machine has six states: IDLE, LD_ACC, LD_WR, DP_RD, DP_OUT, DONE.
- **IDLE**
  - `load_start` → LD_ACC. Word counter = 0; `load_ovf` clears.
  - Otherwise, `halt`=1 and `dump_done`=0 → DP_RD with word counter = 0.
  - If both occur in the same cycle, the load wins.
- **LD_ACC**
  - `load_ready`=1.
  - On `load_valid`: capture `load_data` into `dstore`, capture `load_last` into a flag, then → LD_WR.
- **LD_WR**
  - `dwen`=1; `daddr` = `BASE_ADDR` + 4·counter.
  - On completion (`dwait`=0), counter increments by 1.
  - Exit to IDLE when the flag is set or the counter reaches `NUM_WORDS`. On the `NUM_WORDS` exit without the flag, set `load_ovf`. Otherwise → LD_ACC.
- **DP_RD**
  - `dren`=1; `daddr` = `BASE_ADDR` + 4·counter.
  - On completion, capture `dload` into `dump_data` and `daddr` into `dump_addr`, then → DP_OUT.
- **DP_OUT**
  - `dump_valid`=1; `dump_data` and `dump_addr` stay stable until accepted.
  - When `dump_valid` and `dump_ready` are both high: if counter = `NUM_WORDS`-1 → DONE, otherwise increment the counter and → DP_RD.
- **DONE**
  - Set `dump_done`, then → IDLE.
  - `dump_done` clears only on reset or on `load_start`, which re-arms the dump.
- **Override and hold**
  - `override_ctrl` = 1 in every state except IDLE and DONE.
  - `cpu_hold` = 1 in LD_ACC and LD_WR only.
- **Boundary behaviour**
  - `halt` is ignored while a load is in progress.
  - `halt` dropping during a dump does not abort the dump.
  - `load_start` arriving outside IDLE is ignored.
  - Address arithmetic is 32-bit unsigned; wrap is impossible for legal parameters.
  - The counter is `$clog2(NUM_WORDS+1)` bits wide.

## Timing
- **Reset:** state = IDLE; all outputs are 0, including `override_ctrl`, `cpu_hold`, `dump_valid`, `dump_done`, `load_ovf`, `dstore`, `daddr`, `dump_data` and `dump_addr`. Reset mid-operation aborts immediately and releases the override. A partially written RAM is not restored.
- All outputs are registered or decoded from state and registers only. None depends combinationally on `dwait`, `dload`, `load_valid` or `dump_ready`.
- **Zero-wait memory:**
  - Load: 2 cycles per word (LD_ACC + LD_WR) with a continuously valid stream.
  - Dump: 2 cycles per word (DP_RD + DP_OUT) with `dump_ready` held high.
  - Each `dwait` cycle adds one cycle.
- The request holds steady, with constant address and data, until the completing cycle. It deasserts the cycle after completion.
- The first request asserts exactly one cycle after the IDLE exit.

## Structure
- In `common_types_pkg`:
  - `dump_state_t` enum for the six states.
  - `WORD_W` = 32.
  - `word_t` reuse.
- Single module with no sub-module. The counter/address generator stays inline.
- The system top instantiates it and replaces the `cpu_ram_debug_if` drive with the engine's outputs.

## Test plan
- **Reset values:** assert `nrst`=0 mid-LD_WR → next cycle `override_ctrl`=0, `dwen`=0, `cpu_hold`=0, state = IDLE.
- **Load with waits:** `BASE_ADDR`=0, `NUM_WORDS`=4; load 32'hDEADBEEF, 32'h00000013 (last) with `dwait`=1 for 2 cycles per write → RAM[0]=DEADBEEF, RAM[4]=00000013. Exactly 2 `dwen` completions; `cpu_hold` deasserts 1 cycle after the second completion; `load_ovf`=0.
- **Load overflow:** `NUM_WORDS`=4, five words with no `load_last` → 4 writes to 0x0, 0x4, 0x8, 0xC; `load_ovf`=1; `load_ready`=0 for the fifth word.
- **Dump with backpressure:** RAM = {1,2,3,4}; raise `halt`; `dump_ready` toggles 1/0 → stream (0x0,1),(0x4,2),(0x8,3),(0xC,4) in order, with data stable while stalled. `dump_done`=1 after the last handshake. `halt` held high does not start a second dump.
- **Simultaneous start:** `load_start` and `halt` rise in the same IDLE cycle → LD_ACC entered and no `dren` issued. Once the load ends with `halt` still high, the dump begins.
- **Ignored start:** `load_start` pulsed during DP_OUT → no effect and the dump completes normally. A subsequent `load_start` in IDLE clears `dump_done`.
